// File: rtl/reset_sequencer_if.sv
`timescale 1ns/1ps
// Signal bundle between the reset sequencer and the board/consumer side.
// master = sequencer (drives resets/status), slave = the side supplying lock, requests and acks.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              pll_locked;
    logic              soft_req;
    logic [STAGES-1:0] stage_ack;
    logic [STAGES-1:0] stage_reset;
    logic              seq_done;
    logic              fault;
    logic [2:0]        state;

    modport master (
        input  pll_locked, soft_req, stage_ack,
        output stage_reset, seq_done, fault, state
    );

    modport slave (
        output pll_locked, soft_req, stage_ack,
        input  stage_reset, seq_done, fault, state
    );
endinterface

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// Multi-domain reset sequencer: filters PLL lock, then releases domains in order, each gated on its ack.
// All outputs registered (pll_locked adds 2 sync edges); no backpressure, restarts on lock loss, soft_req or ack timeout.
module reset_sequencer #(
    parameter int STAGES      = 3,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk_in,
    input  logic              reset_n,
    reset_sequencer_if.master bus
);
    localparam logic [2:0] ASSERT_ALL = 3'd0;
    localparam logic [2:0] WAIT_LOCK  = 3'd1;
    localparam logic [2:0] DELAY      = 3'd2;
    localparam logic [2:0] WAIT_ACK   = 3'd3;
    localparam logic [2:0] RUN        = 3'd4;

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int DLY_W = $clog2(STAGE_DELAY + 1);
    localparam int LF_W  = $clog2(LOCK_FILTER + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    // Each phase leaves on the edge its counter would reach the limit, so a
    // phase of N cycles occupies exactly N edges and counters never exceed N-1.
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
    localparam logic [LF_W-1:0]  LF_LAST  = LF_W'(LOCK_FILTER - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STAGES - 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DLY_W-1:0]  dcnt_q, dcnt_d;
    logic [LF_W-1:0]   lcnt_q, lcnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              sync1_q, sync2_q;
    logic [STAGES-1:0] stage_reset_q, stage_reset_d;
    logic              seq_done_q, seq_done_d;
    logic              fault_q, fault_d;
    logic              restart;

    assign restart = !sync2_q || bus.soft_req;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dcnt_d        = dcnt_q;
        lcnt_d        = '0;
        tcnt_d        = tcnt_q;
        stage_reset_d = stage_reset_q;
        seq_done_d    = seq_done_q;
        fault_d       = fault_q;

        // Restart outranks timeout and ack; also catches the unused state codes.
        if (state_q != ASSERT_ALL && (restart || state_q > RUN)) begin
            state_d       = ASSERT_ALL;
            stage_reset_d = '1;
            seq_done_d    = 1'b0;
            dcnt_d        = '0;
        end else begin
            case (state_q)
                ASSERT_ALL: begin
                    stage_reset_d = '1;
                    seq_done_d    = 1'b0;
                    if (dcnt_q == DLY_LAST) begin
                        dcnt_d  = '0;
                        state_d = WAIT_LOCK;
                    end else begin
                        dcnt_d = dcnt_q + DLY_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock is known high here; a low cycle is a restart handled above.
                    if (lcnt_q == LF_LAST) begin
                        idx_d   = '0;
                        dcnt_d  = '0;
                        state_d = DELAY;
                    end else begin
                        lcnt_d = lcnt_q + LF_W'(1);
                    end
                end
                DELAY: begin
                    if (dcnt_q == DLY_LAST) begin
                        stage_reset_d[idx_q] = 1'b0;
                        dcnt_d               = '0;
                        tcnt_d               = '0;
                        state_d              = WAIT_ACK;
                    end else begin
                        dcnt_d = dcnt_q + DLY_W'(1);
                    end
                end
                WAIT_ACK: begin
                    if (tcnt_q == TO_LAST) begin
                        fault_d       = 1'b1;
                        stage_reset_d = '1;
                        dcnt_d        = '0;
                        state_d       = ASSERT_ALL;
                    end else if (bus.stage_ack[idx_q]) begin
                        if (idx_q == IDX_LAST) begin
                            seq_done_d = 1'b1;
                            state_d    = RUN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            dcnt_d  = '0;
                            state_d = DELAY;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = ASSERT_ALL;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ASSERT_ALL;
            idx_q         <= '0;
            dcnt_q        <= '0;
            lcnt_q        <= '0;
            tcnt_q        <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stage_reset_q <= '1;
            seq_done_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dcnt_q        <= dcnt_d;
            lcnt_q        <= lcnt_d;
            tcnt_q        <= tcnt_d;
            sync1_q       <= bus.pll_locked;
            sync2_q       <= sync1_q;
            stage_reset_q <= stage_reset_d;
            seq_done_q    <= seq_done_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.stage_reset = stage_reset_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
endmodule
